mul_rr_scheduler: RTL

//  Shares one combinational signed Baugh-Wooley N x N multiplier between NREQ requesters.

---
 rtl/mul_sched_pkg.sv | 16 +
 rtl/bw_mult_core.sv | 33 +++
 rtl/mul_rr_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared defaults and width helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

   localparam int N_DEFAULT    = 5;
   localparam int NREQ_DEFAULT = 4;

   // A single requester still needs a 1-bit id so the port never collapses to zero width.
   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   function automatic int prod_width(input int n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/bw_mult_core.sv
// Purely combinational signed N x N Baugh-Wooley array multiplier with an exact 2N-bit product.
module bw_mult_core
   import mul_sched_pkg::*;
#(
   parameter  int N  = N_DEFAULT,
   localparam int PW = prod_width(N)
) (
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic [PW-1:0] p
);

   logic [PW-1:0] acc;
   logic          pp;

   // Partial products mixing exactly one sign bit are inverted; the constant
   // 2^N + 2^(2N-1) restores the two's-complement weight of those rows.
   // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch is inferred.
   always_comb begin
      acc = '0;
      pp  = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if ((i == N-1) ^ (j == N-1)) pp = ~(a[j] & b[i]);
            else                         pp = a[j] & b[i];
            acc = acc + (PW'(pp) << (i + j));
         end
      end
      acc = acc + (PW'(1) << N) + (PW'(1) << (PW - 1));
      p   = acc;
   end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin arbiter feeding one shared signed multiplier through an operand stage and a product stage.
module mul_rr_scheduler
   import mul_sched_pkg::*;
#(
   parameter  int N    = N_DEFAULT,
   parameter  int NREQ = NREQ_DEFAULT,
   localparam int IDW  = id_width(NREQ),
   localparam int PW   = prod_width(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDW-1:0]    res_id,
   output logic [PW-1:0]     res_p
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant_id;
   logic           grant_any;
   logic           xfer;
   logic           s1_valid;
   logic [N-1:0]   s1_a;
   logic [N-1:0]   s1_b;
   logic [IDW-1:0] s1_id;
   logic           s1_free;
   logic           s2_free;
   logic [PW-1:0]  prod;

   assign s2_free = !res_valid || res_ready;
   assign s1_free = !s1_valid || s2_free;

   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
   end

   // Ready is forced low during reset even though the empty pipeline would otherwise accept.
   always_comb begin
      req_ready = '0;
      if (grant_any && s1_free && rst_n) req_ready[grant_id] = 1'b1;
   end

   assign xfer = grant_any && s1_free;

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         s1_valid <= 1'b0;
      end else begin
         if (xfer) begin
            s1_valid <= 1'b1;
            rr_ptr   <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + IDW'(1);
         end else if (s2_free) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // NOTE: operand payload is qualified by s1_valid, so it needs no reset and stays a plain flop.
   always_ff @(posedge clk) begin
      if (xfer) begin
         s1_a  <= req_a[int'(grant_id)*N +: N];
         s1_b  <= req_b[int'(grant_id)*N +: N];
         s1_id <= grant_id;
      end
   end

   bw_mult_core #(.N(N)) u_mult (
      .a (s1_a),
      .b (s1_b),
      .p (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_p     <= '0;
         res_id    <= '0;
      end else if (s1_valid && s2_free) begin
         res_valid <= 1'b1;
         res_p     <= prod;
         res_id    <= s1_id;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule
